// File: rtl/nios_fprint_sysid_pkg.sv
// Shared types and constants for the system-ID fingerprint checker and
// the sys-id slave generator.
package nios_fprint_sysid_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ID  = 3'd1,
        LAT_ID = 3'd2,
        RD_TS  = 3'd3,
        LAT_TS = 3'd4,
        FIN    = 3'd5
    } sysid_state_e;

    typedef enum logic [1:0] {
        SR_IDLE = 2'd0,
        SR_REQ  = 2'd1,
        SR_LAT  = 2'd2
    } single_read_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam logic [31:0] SYSID_DEFAULT_TIMESTAMP = 32'd1452977040;

endpackage

// File: rtl/nios_fprint_sysid_checker_if.sv
// Avalon-MM read-only link between the checker (master) and the sys-id slave.
interface nios_fprint_sysid_checker_if;

    // A read is accepted at the first rising edge where avm_read=1 and
    // avm_waitrequest=0; the master holds avm_address/avm_read stable until
    // then. avm_readdata is taken READ_LATENCY edges after acceptance.
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );

endinterface

// File: rtl/nios_fprint_avm_single_read.sv
// Issues one Avalon-MM read at a time; reports accept, data-valid and
// waitrequest-timeout as same-cycle strobes so the sequencer can chain reads.
module nios_fprint_avm_single_read
    import nios_fprint_sysid_pkg::*;
#(
    parameter int READ_LATENCY   = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              go,
    input  logic                              go_addr,
    nios_fprint_sysid_checker_if.master       avm,
    output logic                              rd_accept,
    output logic                              rd_valid,
    output logic                              rd_timeout,
    output logic [31:0]                       rd_data
);

    localparam bit          LAT_ZERO      = (READ_LATENCY == 0);
    localparam logic [2:0]  LAT_LAST      = LAT_ZERO ? 3'd0 : 3'(READ_LATENCY - 1);
    localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

    single_read_state_e state_q, state_d;
    logic        read_q, read_d;
    logic        addr_q, addr_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]  lat_cnt_q, lat_cnt_d;
    logic        stalled;
    logic        accept;
    logic        abort;
    logic        lat_last;

    always_comb begin
        stalled  = (state_q == SR_REQ) && avm.avm_waitrequest;
        accept   = (state_q == SR_REQ) && !avm.avm_waitrequest;
        // Abort on the edge where the stalled count would reach the limit.
        abort    = stalled && (({1'b0, wait_cnt_q} + 17'd1) == TIMEOUT_LIMIT);
        lat_last = (state_q == SR_LAT) && (lat_cnt_q == LAT_LAST);

        rd_accept  = accept;
        rd_valid   = (accept && LAT_ZERO) || lat_last;
        rd_timeout = abort;
        rd_data    = avm.avm_readdata;

        state_d    = state_q;
        read_d     = read_q;
        addr_d     = addr_q;
        wait_cnt_d = wait_cnt_q;
        lat_cnt_d  = lat_cnt_q;

        if (rd_valid || abort) begin
            state_d = SR_IDLE;
            read_d  = 1'b0;
        end else if (accept) begin
            state_d   = SR_LAT;
            read_d    = 1'b0;
            lat_cnt_d = 3'd0;
        end else if (stalled) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end else if (state_q == SR_LAT) begin
            lat_cnt_d = lat_cnt_q + 3'd1;
        end

        // A new request may be launched on the same edge the previous one completes.
        if (go) begin
            state_d    = SR_REQ;
            read_d     = 1'b1;
            addr_d     = go_addr;
            wait_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= SR_IDLE;
            read_q     <= 1'b0;
            addr_q     <= 1'b0;
            wait_cnt_q <= 16'd0;
            lat_cnt_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            read_q     <= read_d;
            addr_q     <= addr_d;
            wait_cnt_q <= wait_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    assign avm.avm_read    = read_q;
    assign avm.avm_address = addr_q;

endmodule

// File: rtl/nios_fprint_sysid_checker.sv
// Reads system ID and build timestamp from the sys-id slave after start and
// reports whether the running bitstream matches the software expectation.
module nios_fprint_sysid_checker
    import nios_fprint_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TIMESTAMP,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    nios_fprint_sysid_checker_if.master  avm,
    output logic                         busy,
    output logic                         done,
    output logic                         match,
    output logic                         id_ok,
    output logic                         ts_ok,
    output logic                         timeout,
    output logic [31:0]                  captured_id,
    output logic [31:0]                  captured_ts,
    output sysid_state_e                 state_dbg
);

    sysid_state_e state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        match_q, match_d;
    logic        id_ok_q, id_ok_d;
    logic        ts_ok_q, ts_ok_d;
    logic        timeout_q, timeout_d;
    logic [31:0] cap_id_q, cap_id_d;
    logic [31:0] cap_ts_q, cap_ts_d;

    logic        rd_go;
    logic        rd_addr;
    logic        rd_accept;
    logic        rd_valid;
    logic        rd_timeout;
    logic [31:0] rd_data;

    nios_fprint_avm_single_read #(
        .READ_LATENCY   (READ_LATENCY),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_single_read (
        .clock      (clock),
        .reset_n    (reset_n),
        .go         (rd_go),
        .go_addr    (rd_addr),
        .avm        (avm),
        .rd_accept  (rd_accept),
        .rd_valid   (rd_valid),
        .rd_timeout (rd_timeout),
        .rd_data    (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        match_d   = match_q;
        id_ok_d   = id_ok_q;
        ts_ok_d   = ts_ok_q;
        timeout_d = timeout_q;
        cap_id_d  = cap_id_q;
        cap_ts_d  = cap_ts_q;
        rd_go     = 1'b0;
        rd_addr   = SYSID_ADDR_ID;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RD_ID;
                    busy_d    = 1'b1;
                    match_d   = 1'b0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                    cap_id_d  = 32'd0;
                    cap_ts_d  = 32'd0;
                    rd_go     = 1'b1;
                    rd_addr   = SYSID_ADDR_ID;
                end
            end
            RD_ID, LAT_ID: begin
                if (rd_valid) begin
                    cap_id_d = rd_data;
                    state_d  = RD_TS;
                    rd_go    = 1'b1;
                    rd_addr  = SYSID_ADDR_TS;
                end else if (rd_accept) begin
                    state_d = LAT_ID;
                end else if (rd_timeout) begin
                    state_d   = FIN;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            RD_TS, LAT_TS: begin
                // Verdict flags are registered together with done so they are valid in FIN.
                if (rd_valid) begin
                    cap_ts_d = rd_data;
                    state_d  = FIN;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    id_ok_d  = (cap_id_q == EXPECTED_ID);
                    ts_ok_d  = (rd_data == EXPECTED_TIMESTAMP);
                    match_d  = (cap_id_q == EXPECTED_ID) && (rd_data == EXPECTED_TIMESTAMP);
                end else if (rd_accept) begin
                    state_d = LAT_TS;
                end else if (rd_timeout) begin
                    state_d   = FIN;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    id_ok_d   = (cap_id_q == EXPECTED_ID);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            match_q   <= 1'b0;
            id_ok_q   <= 1'b0;
            ts_ok_q   <= 1'b0;
            timeout_q <= 1'b0;
            cap_id_q  <= 32'd0;
            cap_ts_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            match_q   <= match_d;
            id_ok_q   <= id_ok_d;
            ts_ok_q   <= ts_ok_d;
            timeout_q <= timeout_d;
            cap_id_q  <= cap_id_d;
            cap_ts_q  <= cap_ts_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign match       = match_q;
    assign id_ok       = id_ok_q;
    assign ts_ok       = ts_ok_q;
    assign timeout     = timeout_q;
    assign captured_id = cap_id_q;
    assign captured_ts = cap_ts_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_nios_fprint_sysid_checker.sv
// Directed bench: two checker instances (zero latency / short timeout, and
// two-cycle latency) against a sys-id slave model with programmable stalls.
module tb_nios_fprint_sysid_checker;
    import nios_fprint_sysid_pkg::*;

    localparam logic [31:0] TS_GOOD = 32'd1452977040;
    localparam logic [31:0] TS_BAD  = 32'd1452977041;
    localparam logic [31:0] JUNK    = 32'hDEAD_BEEF;
    localparam int          STUCK   = 1000;
    localparam int          LAT1    = 2;

    // ---------------- clock / reset ----------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs and slave model ----------------
    logic [1:0]   start = 2'b00;
    logic [1:0]   busy, done, match, id_ok, ts_ok, timeout;
    logic [31:0]  cap_id [2];
    logic [31:0]  cap_ts [2];
    sysid_state_e state_dbg [2];

    logic [1:0]   m_read, m_addr, s_wait;
    logic [31:0]  s_rdata [2];
    int           stall_id [2] = '{0, 0};
    int           stall_ts [2] = '{0, 0};
    logic [31:0]  ts_word  [2] = '{TS_GOOD, TS_GOOD};
    int           stall_cnt [2] = '{0, 0};
    int           lat_left  [2] = '{0, 0};
    logic [1:0]   pend = 2'b00;
    logic [1:0]   lat_addr = 2'b00;

    int           tests_run = 0;
    int           tests_failed = 0;
    logic [31:0]  exp_q [$];

    nios_fprint_sysid_checker_if bus0 ();
    nios_fprint_sysid_checker_if bus1 ();

    assign m_read[0] = bus0.avm_read;
    assign m_addr[0] = bus0.avm_address;
    assign bus0.avm_waitrequest = s_wait[0];
    assign bus0.avm_readdata    = s_rdata[0];
    assign m_read[1] = bus1.avm_read;
    assign m_addr[1] = bus1.avm_address;
    assign bus1.avm_waitrequest = s_wait[1];
    assign bus1.avm_readdata    = s_rdata[1];

    nios_fprint_sysid_checker #(
        .READ_LATENCY(0), .TIMEOUT_CYCLES(4)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start[0]), .avm(bus0),
        .busy(busy[0]), .done(done[0]), .match(match[0]), .id_ok(id_ok[0]),
        .ts_ok(ts_ok[0]), .timeout(timeout[0]), .captured_id(cap_id[0]),
        .captured_ts(cap_ts[0]), .state_dbg(state_dbg[0])
    );

    nios_fprint_sysid_checker #(
        .READ_LATENCY(LAT1), .TIMEOUT_CYCLES(255)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start[1]), .avm(bus1),
        .busy(busy[1]), .done(done[1]), .match(match[1]), .id_ok(id_ok[1]),
        .ts_ok(ts_ok[1]), .timeout(timeout[1]), .captured_id(cap_id[1]),
        .captured_ts(cap_ts[1]), .state_dbg(state_dbg[1])
    );

    // Slave: stalls N cycles per read (N chosen per address); word 0 is 0.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            logic w;
            w = m_read[i] && (stall_cnt[i] < (m_addr[i] ? stall_ts[i] : stall_id[i]));
            s_wait[i] = w;
            if (i == 0)
                s_rdata[i] = (m_read[i] && !w) ? (m_addr[i] ? ts_word[i] : 32'd0) : JUNK;
            else
                s_rdata[i] = (pend[i] && lat_left[i] == 1) ? (lat_addr[i] ? ts_word[i] : 32'd0) : JUNK;
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (m_read[i] && s_wait[i]) stall_cnt[i] <= stall_cnt[i] + 1;
            else                        stall_cnt[i] <= 0;
            if (i == 1 && m_read[i] && !s_wait[i]) begin
                pend[i]     <= 1'b1;
                lat_left[i] <= LAT1;
                lat_addr[i] <= m_addr[i];
            end else if (pend[i]) begin
                lat_left[i] <= lat_left[i] - 1;
                if (lat_left[i] == 1) pend[i] <= 1'b0;
            end
        end
    end

    // ---------------- checking / scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic expect_txn(input logic [31:0] id, input logic [31:0] ts, input logic [3:0] flags);
        exp_q.push_back(id);
        exp_q.push_back(ts);
        exp_q.push_back({28'd0, flags});
    endtask

    // ---------------- driver tasks ----------------
    // Pulses start, then follows the transaction to done; flags = {match,id_ok,ts_ok,timeout}.
    task automatic run_txn(input int i, input int exp_cyc, input int exp_reads);
        int   cyc, reads, unstable;
        logic got, prev_rw, prev_addr;
        @(negedge clock);
        start[i] = 1'b1;
        @(posedge clock);
        #1 start[i] = 1'b0;
        cyc = 0; reads = 0; unstable = 0; got = 1'b0; prev_rw = 1'b0; prev_addr = 1'b0;
        while (!got && cyc < 400) begin
            @(negedge clock);
            cyc++;
            if (prev_rw && !done[i] && (!m_read[i] || m_addr[i] !== prev_addr)) unstable++;
            if (m_read[i]) reads++;
            prev_rw   = m_read[i] && s_wait[i];
            prev_addr = m_addr[i];
            if (done[i]) got = 1'b1;
        end
        check("done_seen", got, 1);
        check("done_cycle", cyc, exp_cyc);
        check("read_cycles", reads, exp_reads);
        check("stall_stable", unstable, 0);
        check("busy_at_done", busy[i], 0);
        if (exp_q.size() >= 3) begin
            check("captured_id", cap_id[i], exp_q.pop_front());
            check("captured_ts", cap_ts[i], exp_q.pop_front());
            check("flags", {28'd0, match[i], id_ok[i], ts_ok[i], timeout[i]}, exp_q.pop_front());
        end else begin
            check("scoreboard_entry", exp_q.size(), 3);
        end
        @(negedge clock);
        check("done_one_cycle", done[i], 0);
        check("read_idle_after", m_read[i], 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int stray;

        repeat (2) @(negedge clock);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_match", match[0], 0);
        check("rst_read", m_read[0], 0);
        check("rst_cap_ts", cap_ts[0], 0);
        check("rst_state", state_dbg[1], IDLE);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Nominal, zero latency, no stalls.
        expect_txn(32'd0, TS_GOOD, 4'b1110);
        run_txn(0, 3, 2);

        // Two-cycle latency, three stalls on each read.
        stall_id[1] = 3; stall_ts[1] = 3;
        expect_txn(32'd0, TS_GOOD, 4'b1110);
        run_txn(1, 13, 8);

        // Timestamp mismatch.
        ts_word[0] = TS_BAD;
        expect_txn(32'd0, TS_BAD, 4'b0100);
        run_txn(0, 3, 2);

        // Waitrequest stuck on the timestamp read, TIMEOUT_CYCLES=4.
        ts_word[0] = TS_GOOD; stall_ts[0] = STUCK;
        expect_txn(32'd0, 32'd0, 4'b0101);
        run_txn(0, 6, 5);
        stall_ts[0] = 0;

        // Start while busy and during FIN: exactly one transaction.
        @(negedge clock); start[0] = 1'b1;
        @(posedge clock); #1 start[0] = 1'b0;
        @(negedge clock); start[0] = 1'b1;
        @(posedge clock); #1 start[0] = 1'b0;
        @(posedge clock); #1;
        check("fin_done", done[0], 1);
        start[0] = 1'b1;
        @(posedge clock); #1 start[0] = 1'b0;
        stray = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (busy[0] || m_read[0]) stray++;
        end
        check("no_retrigger", stray, 0);
        check("status_held", match[0], 1);

        // Held start: restart on the edge after FIN with status cleared.
        @(negedge clock); start[0] = 1'b1;
        @(posedge clock);
        repeat (3) @(negedge clock);
        check("held_done", done[0], 1);
        @(negedge clock);
        check("held_idle_busy", busy[0], 0);
        check("held_idle_state", state_dbg[0], IDLE);
        check("held_match_kept", match[0], 1);
        @(negedge clock);
        check("held_restart_busy", busy[0], 1);
        check("held_restart_state", state_dbg[0], RD_ID);
        check("held_match_clr", match[0], 0);
        check("held_cap_ts_clr", cap_ts[0], 0);
        start[0] = 1'b0;
        repeat (2) @(negedge clock);
        check("held_second_done", done[0], 1);
        check("held_second_match", match[0], 1);

        // Reset while the timestamp read is stalled.
        stall_id[1] = 0; stall_ts[1] = STUCK;
        @(negedge clock); start[1] = 1'b1;
        @(posedge clock); #1 start[1] = 1'b0;
        repeat (5) @(negedge clock);
        check("pre_rst_state", state_dbg[1], RD_TS);
        check("pre_rst_read", m_read[1], 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_read", m_read[1], 0);
        check("arst_addr", m_addr[1], 0);
        check("arst_busy", busy[1], 0);
        check("arst_state", state_dbg[1], IDLE);
        check("arst_match", match[0], 0);
        check("arst_cap_ts", cap_ts[0], 0);
        @(negedge clock); reset_n = 1'b1;
        stall_id[1] = 1; stall_ts[1] = 2;
        repeat (3) @(negedge clock);
        check("post_rst_busy", busy[1], 0);
        check("post_rst_read", m_read[1], 0);
        expect_txn(32'd0, TS_GOOD, 4'b1110);
        run_txn(1, 10, 5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
